gost_28147_89_gamma: RTL

Counter-mode (gamma, GOST 28147-89 sec. 3) controller sitting directly upstream of gost_28147_89 and consuming its output. It seeds the N3/N4 counters by encrypting a loaded IV through the core, then, per 64-bit data block, steps the counters, drives the core with encrypt-only requests, and XORs the returned keystream with input data. Encryption and decryption are the same operation; the key is wired to the core externally.

---
 rtl/gost_28147_89_gamma.sv | 123 ++++++++++++
 1 files changed

// File: rtl/gost_28147_89_gamma.sv
// rtl/gost_28147_89_gamma.sv - GOST 28147-89 gamma (counter) mode controller driving an external block core
module gost_28147_89_gamma #(
    parameter logic [31:0] C1 = 32'h01010104,
    parameter logic [31:0] C2 = 32'h01010101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iv_load,
    input  logic [63:0] iv,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        core_load,
    output logic        core_mode,
    output logic [63:0] core_pdata,
    input  logic [63:0] core_cdata,
    input  logic        core_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_READY = 3'd2;
    localparam logic [2:0] S_STEP  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    logic [2:0]  state;
    logic [31:0] n3;
    logic [31:0] n4;
    logic [63:0] data_reg;
    logic        done_q;
    logic        done_edge;
    logic [31:0] n3_next;
    logic [31:0] n4_next;
    logic [32:0] n4_sum;

    assign core_mode = 1'b0;
    assign done_edge = core_done & ~done_q;

    // N4 steps modulo 2^32-1: fold the carry out of bit 31 back into bit 0
    always_comb begin
        n3_next = n3 + C2;
        n4_sum  = {1'b0, n4} + {1'b0, C1};
        n4_next = n4_sum[32] ? (n4_sum[31:0] + 32'd1) : n4_sum[31:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            n3         <= '0;
            n4         <= '0;
            data_reg   <= '0;
            done_q     <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            core_load  <= 1'b0;
            core_pdata <= '0;
        end else begin
            done_q    <= core_done;
            core_load <= 1'b0;
            in_ready  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (iv_load) begin
                        core_pdata <= iv;
                        core_load  <= 1'b1;
                        state      <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (done_edge) begin
                        n4       <= core_cdata[63:32];
                        n3       <= core_cdata[31:0];
                        in_ready <= 1'b1;
                        state    <= S_READY;
                    end
                end
                S_READY: begin
                    // re-seeding wins over a simultaneously offered block
                    if (iv_load) begin
                        core_pdata <= iv;
                        core_load  <= 1'b1;
                        state      <= S_INIT;
                    end else if (in_valid) begin
                        data_reg   <= in_data;
                        n3         <= n3_next;
                        n4         <= n4_next;
                        core_pdata <= {n4_next, n3_next};
                        core_load  <= 1'b1;
                        state      <= S_STEP;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_STEP: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (done_edge) begin
                        out_data  <= data_reg ^ core_cdata;
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_READY;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
